key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronizes an active-low key, filters bounce with a
// stability counter, and emits a debounced level, press/release pulses and a press count.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                                   EXTCLK,
  input  logic                                   RST_N,
  input  logic                                   KEY_N_IN,
  output logic                                   KEY_LEVEL,
  output logic                                   KEY_PRESS,
  output logic                                   KEY_RELEASE,
  output logic [7:0]                             PRESS_COUNT,
  output logic [1:0]                             DBG_STATE,
  output logic [$clog2(DEBOUNCE_CYCLES+1)-1:0]   DBG_COUNT
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_UP         = 2'd0,
    ST_UP_TO_DOWN = 2'd1,
    ST_DOWN       = 2'd2,
    ST_DOWN_TO_UP = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;

  state_t         state_q, state_nxt;
  logic [CW-1:0]  cnt_q, cnt_nxt;
  logic           level_q, level_nxt;
  logic           press_q, press_nxt;
  logic           release_q, release_nxt;
  logic [7:0]     count_q, count_nxt;

  // Synchronizer resets to the idle (released) level so reset never fakes a press.
  always_ff @(posedge EXTCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], KEY_N_IN};
    end
  end

  assign sync_n = sync_q[SYNC_STAGES-1];

  // State register; all outputs are registered here as well.
  always_ff @(posedge EXTCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      count_q   <= count_nxt;
    end
  end

  // Next state: any opposite sample during a counting run drops the count to zero.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = '0;
    case (state_q)
      ST_UP: begin
        if (!sync_n) begin
          if (SINGLE) begin
            state_nxt = ST_DOWN;
          end else begin
            state_nxt = ST_UP_TO_DOWN;
            cnt_nxt   = CW'(1);
          end
        end
      end
      ST_UP_TO_DOWN: begin
        if (sync_n) begin
          state_nxt = ST_UP;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = ST_DOWN;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      ST_DOWN: begin
        if (sync_n) begin
          if (SINGLE) begin
            state_nxt = ST_UP;
          end else begin
            state_nxt = ST_DOWN_TO_UP;
            cnt_nxt   = CW'(1);
          end
        end
      end
      ST_DOWN_TO_UP: begin
        if (!sync_n) begin
          state_nxt = ST_DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = ST_UP;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_UP;
      end
    endcase
  end

  // Outputs follow the completing transition into DOWN or UP.
  always_comb begin
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    level_nxt   = level_q;
    count_nxt   = count_q;
    if ((state_q == ST_UP || state_q == ST_UP_TO_DOWN) && state_nxt == ST_DOWN) begin
      press_nxt = 1'b1;
      level_nxt = 1'b1;
      count_nxt = count_q + 8'd1;
    end
    if ((state_q == ST_DOWN || state_q == ST_DOWN_TO_UP) && state_nxt == ST_UP) begin
      release_nxt = 1'b1;
      level_nxt   = 1'b0;
    end
  end

  assign KEY_LEVEL   = level_q;
  assign KEY_PRESS   = press_q;
  assign KEY_RELEASE = release_q;
  assign PRESS_COUNT = count_q;
  assign DBG_STATE   = state_q;
  assign DBG_COUNT   = cnt_q;

endmodule
